move_digit_2d: RTL

- Parametrised successor to the fixed-path horizontal digit mover.
- Animates one seven-segment digit across the OLED in a selectable mode: horizontal, vertical or diagonal bounce, or hold.
- Has its own tick divider, position/direction state and bounce pulse.
- Renders the digit combinationally per pixel query (px, py) for the OLED pixel mux.

---
 rtl/move_digit_2d.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/move_digit_2d.sv
// ============================================================================
//  Module      : move_digit_2d
//  Description : Animates one seven-segment digit across the OLED in a
//                horizontal, vertical or diagonal bounce (or hold), with its
//                own motion tick divider and a one-cycle bounce pulse.
//                Pixels are rendered combinationally per (px, py) query.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module move_digit_2d #(
  parameter int OLED_WIDTH      = 96,
  parameter int OLED_HEIGHT     = 64,
  parameter int DIGIT_WIDTH     = 16,
  parameter int DIGIT_HEIGHT    = 24,
  parameter int DIGIT_THICKNESS = 4,
  parameter int TICK_DIV        = 1800000,
  parameter int START_X         = 0,
  parameter int START_Y         = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [2:0]  step,
  input  logic [3:0]  value,
  input  logic [15:0] colour,
  input  logic [6:0]  px,
  input  logic [6:0]  py,
  output logic [15:0] pixel_data,
  output logic [6:0]  pos_x,
  output logic [6:0]  pos_y,
  output logic        bounce
);

  // Tick divider sizing; TICK_DIV >= 2 keeps the width at least one bit.
  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);

  // Travel bounds, clamped at zero when the digit fills the screen.
  localparam int XMAX_I = (OLED_WIDTH  > DIGIT_WIDTH)  ? OLED_WIDTH  - DIGIT_WIDTH  : 0;
  localparam int YMAX_I = (OLED_HEIGHT > DIGIT_HEIGHT) ? OLED_HEIGHT - DIGIT_HEIGHT : 0;
  localparam logic [7:0] XMAX = 8'(XMAX_I);
  localparam logic [7:0] YMAX = 8'(YMAX_I);

  // Segment geometry inside the digit box, in 8-bit local coordinates.
  localparam logic [7:0] W8   = 8'(DIGIT_WIDTH);
  localparam logic [7:0] H8   = 8'(DIGIT_HEIGHT);
  localparam logic [7:0] T8   = 8'(DIGIT_THICKNESS);
  localparam logic [7:0] HALF = 8'(DIGIT_HEIGHT / 2);
  localparam logic [7:0] G_LO = 8'(DIGIT_HEIGHT / 2 - DIGIT_THICKNESS / 2);
  localparam logic [7:0] G_HI = 8'(DIGIT_HEIGHT / 2 + DIGIT_THICKNESS / 2);
  localparam logic [7:0] R_LO = 8'(DIGIT_WIDTH - DIGIT_THICKNESS);
  localparam logic [7:0] D_LO = 8'(DIGIT_HEIGHT - DIGIT_THICKNESS);

  logic [CNT_W-1:0] tick_cnt;
  logic [7:0]       x_q;
  logic [7:0]       y_q;
  logic             x_neg;   // 1 = moving toward 0
  logic             y_neg;

  logic             tick;
  logic [7:0]       s;
  logic             x_act;
  logic             y_act;
  logic [9:0]       x_nxt;   // {hit, neg, pos}
  logic [9:0]       y_nxt;

  // One axis step: clamp to the bound and flip direction when it is reached
  // or passed. 8-bit arithmetic leaves headroom for pos + step.
  function automatic logic [9:0] axis_next(input logic [7:0] pos,
                                           input logic       neg,
                                           input logic [7:0] stp,
                                           input logic [7:0] bound);
    logic [7:0] sum;
    sum = pos + stp;
    if (!neg) begin
      if (sum >= bound) axis_next = {1'b1, 1'b1, bound};
      else              axis_next = {1'b0, 1'b0, sum};
    end else begin
      if (pos <= stp)   axis_next = {1'b1, 1'b0, 8'd0};
      else              axis_next = {1'b0, 1'b1, pos - stp};
    end
  endfunction

  assign tick  = en && (tick_cnt == TICK_LAST);
  assign s     = (step == 3'd0) ? 8'd1 : {5'd0, step};
  assign x_act = (mode == 2'b00) || (mode == 2'b10);
  assign y_act = (mode == 2'b01) || (mode == 2'b10);
  assign x_nxt = axis_next(x_q, x_neg, s, XMAX);
  assign y_nxt = axis_next(y_q, y_neg, s, YMAX);

  // Tick divider, position/direction state and the registered bounce pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      x_q      <= 8'(START_X);
      y_q      <= 8'(START_Y);
      x_neg    <= 1'b0;
      y_neg    <= 1'b0;
      bounce   <= 1'b0;
    end else begin
      if (en) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
      if (tick && x_act) begin
        x_q   <= x_nxt[7:0];
        x_neg <= x_nxt[8];
      end
      if (tick && y_act) begin
        y_q   <= y_nxt[7:0];
        y_neg <= y_nxt[8];
      end
      // A corner hit merges into a single pulse.
      bounce <= tick && ((x_act && x_nxt[9]) || (y_act && y_nxt[9]));
    end
  end

  assign pos_x = x_q[6:0];
  assign pos_y = y_q[6:0];

  // ---------------------------------------------------------------- render
  logic [7:0] lx;
  logic [7:0] ly;
  logic       in_box;
  logic [6:0] seg_hit;   // {a,b,c,d,e,f,g} regions covering (lx, ly)
  logic [6:0] seg_lit;   // {a,b,c,d,e,f,g} lit for the current value

  assign lx     = {1'b0, px} - x_q;
  assign ly     = {1'b0, py} - y_q;
  assign in_box = ({1'b0, px} >= x_q) && ({1'b0, py} >= y_q) && (lx < W8) && (ly < H8);

  assign seg_hit[6] = (ly < T8);
  assign seg_hit[5] = (lx >= R_LO) && (ly < HALF);
  assign seg_hit[4] = (lx >= R_LO) && (ly >= HALF);
  assign seg_hit[3] = (ly >= D_LO);
  assign seg_hit[2] = (lx < T8) && (ly >= HALF);
  assign seg_hit[1] = (lx < T8) && (ly < HALF);
  assign seg_hit[0] = (ly >= G_LO) && (ly < G_HI);

  // Seven-segment decode; codes above 9 leave the digit blank.
  always_comb begin
    seg_lit = 7'b0000000;
    case (value)
      4'd0: seg_lit = 7'b1111110;
      4'd1: seg_lit = 7'b0110000;
      4'd2: seg_lit = 7'b1101101;
      4'd3: seg_lit = 7'b1111001;
      4'd4: seg_lit = 7'b0110011;
      4'd5: seg_lit = 7'b1011011;
      4'd6: seg_lit = 7'b1011111;
      4'd7: seg_lit = 7'b1110000;
      4'd8: seg_lit = 7'b1111111;
      4'd9: seg_lit = 7'b1111011;
      default: seg_lit = 7'b0000000;
    endcase
  end

  assign pixel_data = (in_box && |(seg_hit & seg_lit)) ? colour : 16'h0000;

endmodule

`default_nettype wire
